// File: rtl/wvb_reader_arb_if.sv
// Handshake bundle between the reader arbiter, the per-channel header FIFOs,
// the read controller and the DPRAM readout engine.
interface wvb_reader_arb_if #(
  parameter int unsigned N_CHANNELS  = 24,
  parameter int unsigned P_IDX_WIDTH = 5
);
  logic [N_CHANNELS-1:0]  hdr_empty;
  logic [N_CHANNELS-1:0]  hdr_rdreq;
  logic [P_IDX_WIDTH-1:0] chan_index;
  logic                   rd_ctrl_req;
  logic                   rd_ctrl_ack;
  logic                   dpram_busy;
  logic                   dpram_run;

  modport master (
    input  hdr_empty, rd_ctrl_ack, dpram_busy,
    output hdr_rdreq, chan_index, rd_ctrl_req, dpram_run
  );

  modport slave (
    output hdr_empty, rd_ctrl_ack, dpram_busy,
    input  hdr_rdreq, chan_index, rd_ctrl_req, dpram_run
  );
endinterface

// File: rtl/wvb_reader_arb.sv
// Waveform buffer reader arbiter: picks one eligible channel per readout
// (round-robin or fixed priority) and sequences the read controller / DPRAM handshake.
module wvb_reader_arb #(
  parameter int unsigned N_CHANNELS     = 24,
  parameter int unsigned P_IDX_WIDTH    = 5,
  parameter int unsigned P_BUSY_TIMEOUT = 1024,
  parameter int unsigned P_CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    prio_mode,
  input  logic [N_CHANNELS-1:0]   chan_mask,
  input  logic                    cnt_clr,
  output logic                    busy,
  output logic [P_CNT_WIDTH-1:0]  readout_cnt,
  output logic [P_CNT_WIDTH-1:0]  timeout_cnt,
  wvb_reader_arb_if.master        bus
);

  localparam int unsigned IW1      = P_IDX_WIDTH + 1;
  localparam int unsigned WD_WIDTH = (P_BUSY_TIMEOUT < 2) ? 1 : $clog2(P_BUSY_TIMEOUT + 1);
  localparam int unsigned WD_LAST  = (P_BUSY_TIMEOUT == 0) ? 0 : P_BUSY_TIMEOUT - 1;
  localparam logic [P_IDX_WIDTH-1:0] LAST_RESET = P_IDX_WIDTH'(N_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [P_IDX_WIDTH-1:0] chan_index_q, chan_index_d;
  logic [P_IDX_WIDTH-1:0] last_chan_q, last_chan_d;
  logic [N_CHANNELS-1:0]  hdr_rdreq_q, hdr_rdreq_d;
  logic                   rd_ctrl_req_q, rd_ctrl_req_d;
  logic                   dpram_run_q, dpram_run_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [WD_WIDTH-1:0]    wd_q, wd_d;
  logic [P_CNT_WIDTH-1:0] readout_cnt_q, readout_cnt_d;
  logic [P_CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;

  logic [N_CHANNELS-1:0]  elig;
  logic [N_CHANNELS-1:0]  elig_rot;
  logic [IW1-1:0]         rr_start;
  logic [IW1-1:0]         rr_sum;
  logic [P_IDX_WIDTH-1:0] rr_win, fp_win, winner;
  logic [WD_WIDTH-1:0]    wd_step;
  logic                   wd_expired;
  logic                   rdo_inc, to_inc;

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [IW1-1:0] first_set(input logic [N_CHANNELS-1:0] v);
    logic [IW1-1:0] idx;
    idx = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) idx = IW1'(i);
    end
    return idx;
  endfunction

  assign elig = ~bus.hdr_empty & chan_mask;

  // Rotate so the search starts just after the last served channel, then map back.
  always_comb begin
    rr_start = IW1'(last_chan_q) + IW1'(1);
    if (rr_start >= IW1'(N_CHANNELS)) rr_start = '0;
    elig_rot = N_CHANNELS'({elig, elig} >> rr_start);
    rr_sum   = rr_start + first_set(elig_rot);
    if (rr_sum >= IW1'(N_CHANNELS)) rr_sum = rr_sum - IW1'(N_CHANNELS);
    rr_win   = P_IDX_WIDTH'(rr_sum);
    fp_win   = P_IDX_WIDTH'(first_set(elig));
    winner   = prio_mode ? fp_win : rr_win;
  end

  assign wd_step    = (P_BUSY_TIMEOUT == 0) ? wd_q : wd_q + WD_WIDTH'(1);
  assign wd_expired = (P_BUSY_TIMEOUT != 0) && (wd_q >= WD_WIDTH'(WD_LAST));

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    chan_index_d  = chan_index_q;
    last_chan_d   = last_chan_q;
    hdr_rdreq_d   = '0;
    rd_ctrl_req_d = rd_ctrl_req_q;
    wd_d          = wd_q;
    rdo_inc       = 1'b0;
    to_inc        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|elig && !bus.dpram_busy && !bus.rd_ctrl_ack) begin
          state_d       = S_REQ;
          chan_index_d  = winner;
          hdr_rdreq_d   = N_CHANNELS'(1) << winner;
          rd_ctrl_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.rd_ctrl_ack) begin
          state_d       = S_WAIT_BUSY;
          rd_ctrl_req_d = 1'b0;
          wd_d          = '0;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.dpram_busy) begin
          state_d = S_WAIT_DONE;
          wd_d    = wd_step;
        end else if (wd_expired) begin
          state_d     = S_IDLE;
          last_chan_d = chan_index_q;
          to_inc      = 1'b1;
        end else begin
          wd_d = wd_step;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.dpram_busy) begin
          state_d     = S_IDLE;
          last_chan_d = chan_index_q;
          rdo_inc     = 1'b1;
        end else if (wd_expired) begin
          state_d     = S_IDLE;
          last_chan_d = chan_index_q;
          to_inc      = 1'b1;
        end else begin
          wd_d = wd_step;
        end
      end
      default: begin
        state_d       = S_IDLE;
        rd_ctrl_req_d = 1'b0;
      end
    endcase

    // Disable acts as a soft reset that leaves the statistics counters alone.
    if (!en) begin
      state_d       = S_IDLE;
      chan_index_d  = '0;
      last_chan_d   = LAST_RESET;
      hdr_rdreq_d   = '0;
      rd_ctrl_req_d = 1'b0;
      wd_d          = '0;
      rdo_inc       = 1'b0;
      to_inc        = 1'b0;
    end

    busy_d      = (state_d != S_IDLE);
    ack_d       = en & bus.rd_ctrl_ack;
    dpram_run_d = en & bus.rd_ctrl_ack & ~ack_q;

    readout_cnt_d = readout_cnt_q;
    if (cnt_clr) readout_cnt_d = '0;
    else if (rdo_inc && (readout_cnt_q != '1)) readout_cnt_d = readout_cnt_q + P_CNT_WIDTH'(1);

    timeout_cnt_d = timeout_cnt_q;
    if (cnt_clr) timeout_cnt_d = '0;
    else if (to_inc && (timeout_cnt_q != '1)) timeout_cnt_d = timeout_cnt_q + P_CNT_WIDTH'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      chan_index_q  <= '0;
      last_chan_q   <= LAST_RESET;
      hdr_rdreq_q   <= '0;
      rd_ctrl_req_q <= 1'b0;
      dpram_run_q   <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
      readout_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      chan_index_q  <= chan_index_d;
      last_chan_q   <= last_chan_d;
      hdr_rdreq_q   <= hdr_rdreq_d;
      rd_ctrl_req_q <= rd_ctrl_req_d;
      dpram_run_q   <= dpram_run_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      wd_q          <= wd_d;
      readout_cnt_q <= readout_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign bus.hdr_rdreq   = hdr_rdreq_q;
  assign bus.chan_index  = chan_index_q;
  assign bus.rd_ctrl_req = rd_ctrl_req_q;
  assign bus.dpram_run   = dpram_run_q;
  assign busy            = busy_q;
  assign readout_cnt     = readout_cnt_q;
  assign timeout_cnt     = timeout_cnt_q;

endmodule

// File: tb/tb_wvb_reader_arb.sv
// Self-checking bench for wvb_reader_arb: directed table, hand-written corner
// sequences and randomized readouts against a transaction-level model.
module tb_wvb_reader_arb;
  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          prio_mode;
  logic [N-1:0]  chan_mask;
  logic          cnt_clr;
  logic          busy;
  logic [CW-1:0] readout_cnt;
  logic [CW-1:0] timeout_cnt;

  wvb_reader_arb_if #(.N_CHANNELS(N), .P_IDX_WIDTH(IW)) bus ();

  wvb_reader_arb #(
    .N_CHANNELS(N), .P_IDX_WIDTH(IW), .P_BUSY_TIMEOUT(TO), .P_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .prio_mode(prio_mode), .chan_mask(chan_mask),
    .cnt_clr(cnt_clr), .busy(busy), .readout_cnt(readout_cnt),
    .timeout_cnt(timeout_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: last served channel and saturating counters.
  int m_last = N - 1;
  int m_rd   = 0;
  int m_to   = 0;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] empty;
    logic         prio;
    int           mode;      // 0 = normal readout, 1 = dpram_busy never comes
    int           exp_chan;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Winner from the arbitration rules; -1 when nothing is eligible.
  function automatic int model_winner(input logic [N-1:0] elig, input logic prio);
    if (prio) begin
      for (int c = 0; c < N; c++) if (elig[c]) return c;
    end else begin
      for (int d = 1; d <= N; d++) if (elig[(m_last + d) % N]) return (m_last + d) % N;
    end
    return -1;
  endfunction

  task automatic scramble();
    chan_mask     = N'($urandom);
    bus.hdr_empty = N'($urandom);
    prio_mode     = 1'($urandom_range(0, 1));
  endtask

  // One readout from an idle DUT; exp_c < 0 means no grant may happen.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] empty,
                         input logic prio, input int mode, input int blen, input int exp_c);
    int   w;
    logic seen;
    chan_mask     = mask;
    bus.hdr_empty = empty;
    prio_mode     = prio;
    if (exp_c < 0) begin
      seen = 1'b0;
      repeat (3) begin
        step();
        if (bus.rd_ctrl_req || (bus.hdr_rdreq != '0) || busy) seen = 1'b1;
      end
      check("idle_no_grant", 32'(seen), 32'(0));
      return;
    end
    w = 0;
    do begin
      step();
      w++;
    end while (!bus.rd_ctrl_req && w < 8);
    check("grant_latency", 32'(w), 32'(1));
    if (!bus.rd_ctrl_req) return;
    check("hdr_rdreq_onehot", 32'(bus.hdr_rdreq), 32'(1) << exp_c);
    check("chan_index", 32'(bus.chan_index), 32'(exp_c));
    repeat ($urandom_range(0, 2)) begin
      scramble();
      step();
    end
    bus.rd_ctrl_ack = 1'b1;
    step();
    check("req_drop_on_ack", 32'(bus.rd_ctrl_req), 32'(0));
    check("dpram_run_pulse", 32'(bus.dpram_run), 32'(1));
    check("hdr_rdreq_single", 32'(bus.hdr_rdreq), 32'(0));
    bus.rd_ctrl_ack = 1'b0;
    if (mode == 1) begin
      repeat (TO - 1) begin
        scramble();
        step();
      end
      check("busy_before_timeout", 32'(busy), 32'(1));
      step();
      m_to = sat_inc(m_to);
    end else begin
      repeat ($urandom_range(0, 2)) begin
        scramble();
        step();
      end
      bus.dpram_busy = 1'b1;
      repeat (blen) begin
        scramble();
        step();
      end
      bus.dpram_busy = 1'b0;
      step();
      m_rd = sat_inc(m_rd);
    end
    check("done_busy", 32'(busy), 32'(0));
    check("chan_index_stable", 32'(bus.chan_index), 32'(exp_c));
    check("readout_cnt", 32'(readout_cnt), 32'(m_rd));
    check("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
    m_last = exp_c;
  endtask

  // Runs a readout up to the S_WAIT_DONE phase (dpram_busy held high).
  task automatic start_readout();
    int w;
    chan_mask     = '1;
    bus.hdr_empty = '0;
    prio_mode     = 1'b0;
    w = 0;
    do begin
      step();
      w++;
    end while (!bus.rd_ctrl_req && w < 8);
    check("partial_grant", 32'(bus.rd_ctrl_req), 32'(1));
    bus.rd_ctrl_ack = 1'b1;
    step();
    bus.rd_ctrl_ack = 1'b0;
    bus.dpram_busy  = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic         seen0, seen_busy;
    logic [N-1:0] m, e;
    logic         p;
    int           mode, exp_c;

    tbl[0]  = '{4'hF, 4'b0000, 1'b0, 0, 0};
    tbl[1]  = '{4'hF, 4'b0000, 1'b0, 0, 1};
    tbl[2]  = '{4'hF, 4'b0000, 1'b0, 0, 2};
    tbl[3]  = '{4'hF, 4'b0000, 1'b0, 0, 3};
    tbl[4]  = '{4'hF, 4'b0000, 1'b0, 0, 0};
    tbl[5]  = '{4'hF, 4'b1101, 1'b0, 0, 1};
    tbl[6]  = '{4'hF, 4'b0101, 1'b0, 0, 3};
    tbl[7]  = '{4'hF, 4'b0101, 1'b0, 0, 1};
    tbl[8]  = '{4'hF, 4'b1010, 1'b1, 0, 0};
    tbl[9]  = '{4'hF, 4'b1010, 1'b1, 0, 0};
    tbl[10] = '{4'hF, 4'b1010, 1'b1, 0, 0};
    tbl[11] = '{4'b1110, 4'b0000, 1'b0, 0, 1};
    tbl[12] = '{4'hF, 4'b0000, 1'b0, 1, 2};
    tbl[13] = '{4'hF, 4'b0000, 1'b0, 0, 3};

    rst             = 1'b1;
    en              = 1'b1;
    prio_mode       = 1'b0;
    chan_mask       = '1;
    cnt_clr         = 1'b0;
    bus.hdr_empty   = '1;
    bus.rd_ctrl_ack = 1'b0;
    bus.dpram_busy  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_chan_index", 32'(bus.chan_index), 32'(0));
    check("rst_hdr_rdreq", 32'(bus.hdr_rdreq), 32'(0));
    check("rst_rd_ctrl_req", 32'(bus.rd_ctrl_req), 32'(0));
    check("rst_dpram_run", 32'(bus.dpram_run), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_readout_cnt", 32'(readout_cnt), 32'(0));
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'(0));

    foreach (tbl[i]) run_txn(tbl[i].mask, tbl[i].empty, tbl[i].prio, tbl[i].mode, 10, tbl[i].exp_chan);
    check("table_readouts", 32'(readout_cnt), 32'(13));
    check("table_timeouts", 32'(timeout_cnt), 32'(1));

    // Only masked channel 0 has data: nothing may happen.
    chan_mask     = 4'b1110;
    bus.hdr_empty = 4'b1110;
    seen0     = 1'b0;
    seen_busy = 1'b0;
    repeat (20) begin
      step();
      if (bus.hdr_rdreq[0]) seen0 = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check("masked_ch0_rdreq", 32'(seen0), 32'(0));
    check("masked_ch0_busy", 32'(seen_busy), 32'(0));

    // Disable in S_WAIT_DONE: back to idle, counters kept.
    start_readout();
    check("wait_done_busy", 32'(busy), 32'(1));
    en = 1'b0;
    step();
    check("dis_req", 32'(bus.rd_ctrl_req), 32'(0));
    check("dis_busy", 32'(busy), 32'(0));
    check("dis_readout_cnt", 32'(readout_cnt), 32'(13));
    check("dis_timeout_cnt", 32'(timeout_cnt), 32'(1));
    bus.hdr_empty  = '1;
    bus.dpram_busy = 1'b0;
    en = 1'b1;
    step();

    // Clear coinciding with a completion wins.
    start_readout();
    cnt_clr        = 1'b1;
    bus.dpram_busy = 1'b0;
    step();
    cnt_clr = 1'b0;
    check("clr_readout_cnt", 32'(readout_cnt), 32'(0));
    check("clr_timeout_cnt", 32'(timeout_cnt), 32'(0));
    check("clr_busy", 32'(busy), 32'(0));

    rst           = 1'b1;
    bus.hdr_empty = '1;
    repeat (2) step();
    rst    = 1'b0;
    m_last = N - 1;
    m_rd   = 0;
    m_to   = 0;

    for (int t = 0; t < 90; t++) begin
      m    = N'($urandom);
      e    = N'($urandom);
      p    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) e = '1;
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      exp_c = model_winner(~e & m, p);
      run_txn(m, e, p, mode, $urandom_range(1, 10), exp_c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
